program_memory: RTL

// - Memory responder on the processor's CS/R_NW bus; the sequencer's MAR/MDR/CS/R_NW are the initiator side.
// - Holds program and ciphertext words, with a combinational read and a synchronous write.
// - A ready/valid loader port preloads the array after reset; run releases the processor.
// - Writes to OUT_ADDR also drive a registered output port carrying the decrypted result.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/program_memory_mem_array.sv | 25 ++
 rtl/program_memory.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared processor/memory constants and the program memory state type.
package cpu_pkg;

    localparam int unsigned WORD_W   = 10;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned ADDR_W   = WORD_W - OP_W;
    localparam int unsigned OUT_ADDR = (2 ** ADDR_W) - 1;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } mem_state_t;

endpackage

// File: rtl/program_memory_mem_array.sv
// Word array with one synchronous write port and one asynchronous read port; contents are not reset.
module mem_array #(
    parameter int unsigned WORD_W = 10,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_memory.sv
// Program/ciphertext memory on the processor bus, with a ready/valid preloader,
// a run release to the processor, and a registered output port mirroring OUT_ADDR writes.
module program_memory #(
    parameter  int unsigned WORD_W   = cpu_pkg::WORD_W,
    parameter  int unsigned OP_W     = cpu_pkg::OP_W,
    localparam int unsigned ADDR_W   = WORD_W - OP_W,
    parameter  int unsigned DEPTH    = 2 ** (WORD_W - OP_W),
    parameter  int unsigned OUT_ADDR = DEPTH - 1
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              CS,
    input  logic              R_NW,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    input  logic              ld_valid,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              run,
    output logic [WORD_W-1:0] out_data,
    output logic              out_strobe,
    output logic              err_flag
);

    import cpu_pkg::*;

    mem_state_t        state;
    logic [ADDR_W-1:0] ptr;
    logic              load_fire;
    logic              bus_rd;
    logic              bus_wr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;

    // ld_ready is held low while reset is asserted so no beat is offered during reset.
    assign ld_ready  = n_reset && (state == S_LOAD);
    assign run       = (state == S_RUN);
    assign load_fire = ld_valid && ld_ready;
    assign bus_rd    = (state == S_RUN) && CS && R_NW;
    assign bus_wr    = (state == S_RUN) && CS && !R_NW;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = wdata;
        if (state == S_LOAD) begin
            mem_we    = load_fire;
            mem_waddr = ptr;
            mem_wdata = ld_data;
        end else begin
            mem_we    = bus_wr;
        end
    end

    mem_array #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clock (clock),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (addr),
        .rdata (mem_rdata)
    );

    assign rdata = bus_rd ? mem_rdata : '0;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state      <= S_LOAD;
            ptr        <= '0;
            out_data   <= '0;
            out_strobe <= 1'b0;
            err_flag   <= 1'b0;
        end else begin
            out_strobe <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (CS) begin
                        err_flag <= 1'b1;
                    end
                    if (load_fire) begin
                        // The pointer saturates on the final slot; the state change ends loading.
                        if (ptr != ADDR_W'(DEPTH - 1)) begin
                            ptr <= ptr + 1'b1;
                        end
                        if (ld_last || (ptr == ADDR_W'(DEPTH - 1))) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (bus_wr && (addr == ADDR_W'(OUT_ADDR))) begin
                        out_data   <= wdata;
                        out_strobe <= 1'b1;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule
